// File: rtl/relu_maxpool_pkg.sv
// Shared definitions for the post-convolution ReLU/max-pool stage: FSM
// state encodings and the flat row-major element offset used with conv_top.
package relu_maxpool_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Bit offset of element (r,c) in a row-major map of width w, element width dw.
   function automatic int elem_off(input int r, input int c, input int w, input int dw);
      return (r * w + c) * dw;
   endfunction

endpackage

// File: rtl/relu_maxpool_pool_window_max.sv
// Combinational ReLU-max over one POOL x POOL window of signed elements.
// Negative elements count as zero, so the result is always non-negative.
module pool_window_max #(
   parameter int POOL   = 2,
   parameter int DATA_W = 8
) (
   input  logic [POOL*POOL*DATA_W-1:0] window,
   output logic [DATA_W-1:0]           max_out
);

   logic [DATA_W-1:0] elem;

   // NOTE: always_comb uses blocking assignments and gives every output a
   // default first, so the running max never implies a latch.
   always_comb begin
      max_out = '0;
      elem    = '0;
      for (int i = 0; i < POOL * POOL; i++) begin
         elem = window[i*DATA_W +: DATA_W];
         // Starting from zero and skipping MSB-set elements is the ReLU.
         if (!elem[DATA_W-1] && (elem > max_out))
            max_out = elem;
      end
   end

endmodule

// File: rtl/relu_maxpool.sv
// ReLU + max-pooling stage after conv_top: latches the conv result on a
// pool_en rising edge, writes one pooled slot per clock, then pulses pool_fin.
module relu_maxpool
   import relu_maxpool_pkg::*;
#(
   parameter int IN_W        = 3,
   parameter int IN_H        = 3,
   parameter int DATA_W      = 8,
   parameter int POOL        = 2,
   parameter int POOL_STRIDE = 1,
   localparam int OUT_W      = (IN_W - POOL) / POOL_STRIDE + 1,
   localparam int OUT_H      = (IN_H - POOL) / POOL_STRIDE + 1
) (
   input  logic                          clk_en,
   input  logic                          rst_n,
   input  logic                          pool_en,
   input  logic [IN_W*IN_H*DATA_W-1:0]   feat_in,
   output logic [OUT_W*OUT_H*DATA_W-1:0] pool_out,
   output logic                          pool_fin,
   output logic                          busy
);

   localparam int OX_W = $clog2(OUT_W + 1);
   localparam int OY_W = $clog2(OUT_H + 1);

   generate
      if (POOL > IN_W || POOL > IN_H)
         $error("relu_maxpool: POOL must not exceed the input map size");
      if (POOL_STRIDE < 1)
         $error("relu_maxpool: POOL_STRIDE must be at least 1");
   endgenerate

   state_t                          state;
   logic                            pool_en_d;
   logic [OX_W-1:0]                 ox;
   logic [OY_W-1:0]                 oy;
   logic [IN_W*IN_H*DATA_W-1:0]     feat_q;
   logic [POOL*POOL*DATA_W-1:0]     window;
   logic [DATA_W-1:0]               win_max;
   logic                            start;
   logic                            last_slot;

   assign start     = pool_en & ~pool_en_d;
   assign last_slot = (ox == OX_W'(OUT_W - 1)) && (oy == OY_W'(OUT_H - 1));

   // Gather the current window from the captured map.
   always_comb begin
      window = '0;
      for (int wr = 0; wr < POOL; wr++) begin
         for (int wc = 0; wc < POOL; wc++) begin
            window[(wr*POOL+wc)*DATA_W +: DATA_W] =
               feat_q[elem_off(int'(oy) * POOL_STRIDE + wr,
                               int'(ox) * POOL_STRIDE + wc, IN_W, DATA_W) +: DATA_W];
         end
      end
   end

   pool_window_max #(
      .POOL   (POOL),
      .DATA_W (DATA_W)
   ) u_window_max (
      .window  (window),
      .max_out (win_max)
   );

   always_ff @(posedge clk_en) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         pool_en_d <= 1'b0;
         ox        <= '0;
         oy        <= '0;
         pool_out  <= '0;
         pool_fin  <= 1'b0;
         busy      <= 1'b0;
         // NOTE: feat_q is deliberately left out of reset; it is always
         // loaded on the start edge before anything reads it.
      end else begin
         pool_en_d <= pool_en;
         pool_fin  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  feat_q   <= feat_in;
                  pool_out <= '0;
                  ox       <= '0;
                  oy       <= '0;
                  busy     <= 1'b1;
                  state    <= ST_RUN;
               end
            end
            ST_RUN: begin
               pool_out[elem_off(int'(oy), int'(ox), OUT_W, DATA_W) +: DATA_W] <= win_max;
               if (last_slot) begin
                  pool_fin <= 1'b1;
                  state    <= ST_DONE;
               end else if (ox == OX_W'(OUT_W - 1)) begin
                  ox <= '0;
                  oy <= oy + 1'b1;
               end else begin
                  ox <= ox + 1'b1;
               end
            end
            ST_DONE: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
